// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage
// Brief    : Writeback stage. Holds the MEM/WB register, aligns sub-word loads,
//            drives the register-file write port and counts retired instructions.
// Revision : 1.0 - initial release
// ============================================================================
module wb_stage #(
  parameter int CNT_W      = 32,
  parameter bit ZERO_GUARD = 1'b1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             stall,
  input  logic             flush,
  input  logic             mem_valid,
  input  logic             MemtoReg,
  input  logic             do_writeback,
  input  logic [4:0]       writeRegister,
  input  logic [31:0]      aluResult,
  input  logic [31:0]      data_read,
  input  logic [31:0]      rt_old,
  input  logic [5:0]       ALU_control,
  input  logic [31:0]      Instr,
  output logic [31:0]      writeData_WB,
  output logic [4:0]       writeRegister_WB,
  output logic             do_writeback_WB,
  output logic [31:0]      Instr_WB,
  output logic             misalign_err,
  output logic [CNT_W-1:0] retired_count
);

  localparam logic [5:0] c_OP_LB  = 6'b100001;
  localparam logic [5:0] c_OP_LBU = 6'b101010;
  localparam logic [5:0] c_OP_LH  = 6'b101011;
  localparam logic [5:0] c_OP_LHU = 6'b101100;
  localparam logic [5:0] c_OP_LWL = 6'b101101;
  localparam logic [5:0] c_OP_LWR = 6'b101110;

  logic             r_valid;
  logic             r_memtoreg;
  logic             r_do_writeback;
  logic [4:0]       r_write_register;
  logic [31:0]      r_alu_result;
  logic [31:0]      r_data_read;
  logic [31:0]      r_rt_old;
  logic [5:0]       r_alu_control;
  logic [31:0]      r_instr;
  logic [CNT_W-1:0] r_retired;

  // MEM/WB register: flush beats stall beats load
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_valid          <= 1'b0;
      r_memtoreg       <= 1'b0;
      r_do_writeback   <= 1'b0;
      r_write_register <= 5'd0;
      r_alu_result     <= 32'd0;
      r_data_read      <= 32'd0;
      r_rt_old         <= 32'd0;
      r_alu_control    <= 6'd0;
      r_instr          <= 32'd0;
    end else if (flush) begin
      r_valid          <= 1'b0;
      r_memtoreg       <= 1'b0;
      r_do_writeback   <= 1'b0;
      r_write_register <= 5'd0;
      r_alu_result     <= 32'd0;
      r_data_read      <= 32'd0;
      r_rt_old         <= 32'd0;
      r_alu_control    <= 6'd0;
      r_instr          <= 32'd0;
    end else if (!stall) begin
      r_valid          <= mem_valid;
      r_memtoreg       <= MemtoReg;
      r_do_writeback   <= do_writeback;
      r_write_register <= writeRegister;
      r_alu_result     <= aluResult;
      r_data_read      <= data_read;
      r_rt_old         <= rt_old;
      r_alu_control    <= ALU_control;
      r_instr          <= Instr;
    end
  end

  // The instruction in WB retires when it leaves; a stalled flush drops it.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_retired <= '0;
    end else if (r_valid && !stall) begin
      r_retired <= r_retired + CNT_W'(1);
    end
  end

  logic [1:0]  w_k;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [4:0]  w_shl;
  logic [4:0]  w_shr;
  logic [31:0] w_lwl;
  logic [31:0] w_lwr;
  logic [31:0] w_aligned;
  logic        w_is_half;
  logic        w_misalign;
  logic        w_zero_block;

  assign w_k = r_alu_result[1:0];

  // Big-endian lanes: offset 0 is the most significant byte
  always_comb begin
    w_byte = r_data_read[31:24];
    case (w_k)
      2'd0:    w_byte = r_data_read[31:24];
      2'd1:    w_byte = r_data_read[23:16];
      2'd2:    w_byte = r_data_read[15:8];
      default: w_byte = r_data_read[7:0];
    endcase
  end

  assign w_half = r_alu_result[1] ? r_data_read[15:0] : r_data_read[31:16];

  assign w_shl = {w_k, 3'b000};
  assign w_shr = {~w_k, 3'b000};
  assign w_lwl = (r_data_read << w_shl) | (r_rt_old & ((32'd1 << w_shl) - 32'd1));
  assign w_lwr = (r_rt_old & ~(32'hFFFF_FFFF >> w_shr)) | (r_data_read >> w_shr);

  always_comb begin
    w_aligned = r_data_read;
    case (r_alu_control)
      c_OP_LB:  w_aligned = {{24{w_byte[7]}}, w_byte};
      c_OP_LBU: w_aligned = {24'd0, w_byte};
      c_OP_LH:  w_aligned = {{16{w_half[15]}}, w_half};
      c_OP_LHU: w_aligned = {16'd0, w_half};
      c_OP_LWL: w_aligned = w_lwl;
      c_OP_LWR: w_aligned = w_lwr;
      default:  w_aligned = r_data_read;
    endcase
  end

  assign w_is_half    = (r_alu_control == c_OP_LH) || (r_alu_control == c_OP_LHU);
  assign w_misalign   = r_valid && r_memtoreg && w_is_half && r_alu_result[0];
  assign w_zero_block = ZERO_GUARD && (r_write_register == 5'd0);

  assign writeData_WB     = w_misalign ? 32'd0 : (r_memtoreg ? w_aligned : r_alu_result);
  assign writeRegister_WB = r_write_register;
  assign do_writeback_WB  = r_valid && r_do_writeback && !w_misalign && !w_zero_block;
  assign Instr_WB         = r_instr;
  assign misalign_err     = w_misalign;
  assign retired_count    = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_stage
// Brief    : Self-checking bench for wb_stage against a byte-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_stage;

  localparam logic [5:0] c_LB  = 6'b100001;
  localparam logic [5:0] c_LBU = 6'b101010;
  localparam logic [5:0] c_LH  = 6'b101011;
  localparam logic [5:0] c_LHU = 6'b101100;
  localparam logic [5:0] c_LWL = 6'b101101;
  localparam logic [5:0] c_LWR = 6'b101110;

  logic        CLK, RESET, stall, flush, mem_valid, MemtoReg, do_writeback;
  logic [4:0]  writeRegister;
  logic [31:0] aluResult, data_read, rt_old, Instr;
  logic [5:0]  ALU_control;

  logic [31:0] wd, ins, wd4, ins4;
  logic [4:0]  wr, wr4;
  logic        dwb, mis, dwb4, mis4;
  logic [31:0] cnt32;
  logic [3:0]  cnt4;

  int n_tests = 0;
  int n_fail  = 0;

  wb_stage #(.CNT_W(32), .ZERO_GUARD(1'b1)) dut (
    .CLK(CLK), .RESET(RESET), .stall(stall), .flush(flush), .mem_valid(mem_valid),
    .MemtoReg(MemtoReg), .do_writeback(do_writeback), .writeRegister(writeRegister),
    .aluResult(aluResult), .data_read(data_read), .rt_old(rt_old), .ALU_control(ALU_control),
    .Instr(Instr), .writeData_WB(wd), .writeRegister_WB(wr), .do_writeback_WB(dwb),
    .Instr_WB(ins), .misalign_err(mis), .retired_count(cnt32)
  );

  wb_stage #(.CNT_W(4), .ZERO_GUARD(1'b0)) dut4 (
    .CLK(CLK), .RESET(RESET), .stall(stall), .flush(flush), .mem_valid(mem_valid),
    .MemtoReg(MemtoReg), .do_writeback(do_writeback), .writeRegister(writeRegister),
    .aluResult(aluResult), .data_read(data_read), .rt_old(rt_old), .ALU_control(ALU_control),
    .Instr(Instr), .writeData_WB(wd4), .writeRegister_WB(wr4), .do_writeback_WB(dwb4),
    .Instr_WB(ins4), .misalign_err(mis4), .retired_count(cnt4)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: the instruction sitting in WB plus a retirement tally
  typedef struct {
    logic        v, m2r, dwb;
    logic [4:0]  wreg;
    logic [31:0] alu, data, rt, instr;
    logic [5:0]  ctl;
  } wb_t;

  wb_t         m;
  int unsigned m_cnt;

  function automatic void clear_model();
    m.v = 0; m.m2r = 0; m.dwb = 0; m.wreg = 0;
    m.alu = 0; m.data = 0; m.rt = 0; m.instr = 0; m.ctl = 0;
  endfunction

  function automatic logic [7:0] lane(input logic [31:0] w, input int i);
    logic [31:0] t;
    t = w >> (8 * (3 - i));
    return t[7:0];
  endfunction

  function automatic logic exp_mis();
    return m.v && m.m2r && (m.ctl == c_LH || m.ctl == c_LHU) && m.alu[0];
  endfunction

  function automatic logic [31:0] exp_wd();
    int k, base;
    logic [7:0]  b, hi, lo;
    logic [31:0] r;
    if (exp_mis()) return 32'd0;
    if (!m.m2r) return m.alu;
    k    = int'(m.alu[1:0]);
    base = k & 2;
    b    = lane(m.data, k);
    hi   = lane(m.data, base);
    lo   = lane(m.data, base + 1);
    r    = 32'd0;
    case (m.ctl)
      c_LB:  return {{24{b[7]}}, b};
      c_LBU: return {24'd0, b};
      c_LH:  return {{16{hi[7]}}, hi, lo};
      c_LHU: return {16'd0, hi, lo};
      c_LWL: begin
        // Memory bytes k.. fill the top of the register, rt keeps the rest
        for (int i = 0; i < 4; i++)
          r = (r << 8) | 32'(((i + k) <= 3) ? lane(m.data, i + k) : lane(m.rt, i));
        return r;
      end
      c_LWR: begin
        for (int i = 0; i < 4; i++)
          r = (r << 8) | 32'((i >= 3 - k) ? lane(m.data, i - (3 - k)) : lane(m.rt, i));
        return r;
      end
      default: return m.data;
    endcase
  endfunction

  function automatic logic exp_dwb(input bit zg);
    return m.v && m.dwb && !exp_mis() && !(zg && m.wreg == 5'd0);
  endfunction

  task automatic drive(input logic v, input logic m2r, input logic dw, input logic [4:0] wreg,
                       input logic [31:0] alu, input logic [31:0] dr, input logic [31:0] rt,
                       input logic [5:0] ctl, input logic [31:0] ins_w);
    stall = 0; flush = 0; mem_valid = v; MemtoReg = m2r; do_writeback = dw;
    writeRegister = wreg; aluResult = alu; data_read = dr; rt_old = rt;
    ALU_control = ctl; Instr = ins_w;
  endtask

  task automatic tick();
    @(posedge CLK);
    if (m.v && !stall) m_cnt++;
    if (flush) clear_model();
    else if (!stall) begin
      m.v = mem_valid; m.m2r = MemtoReg; m.dwb = do_writeback; m.wreg = writeRegister;
      m.alu = aluResult; m.data = data_read; m.rt = rt_old; m.ctl = ALU_control; m.instr = Instr;
    end
    #1;
  endtask

  task automatic apply_reset();
    #2 RESET = 1'b1;
    clear_model();
    m_cnt = 0;
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    RESET = 1'b1;
    clear_model();
    m_cnt = 0;
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    n_tests++;
    if ({wd, wr, dwb, ins, mis, cnt32, cnt4} !== 107'd0) begin
      n_fail++;
      $display("FAIL reset_initial: got wd=%h wr=%0d dwb=%b ins=%h mis=%b cnt=%0d cnt4=%0d, expected all 0",
               wd, wr, dwb, ins, mis, cnt32, cnt4);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 1, 5'(i + 3), 32'hCAFE_0000 + 32'(i), 0, 0, 6'd0, 32'h1000_0000 + 32'(i));
      tick();
    end
    // Assert reset between edges: outputs must clear immediately
    #2 RESET = 1'b1;
    #1;
    n_tests++;
    if ({wd, wr, dwb, ins, mis, cnt32, cnt4} !== 107'd0) begin
      n_fail++;
      $display("FAIL reset_async: got wd=%h wr=%0d dwb=%b ins=%h mis=%b cnt=%0d cnt4=%0d, expected all 0",
               wd, wr, dwb, ins, mis, cnt32, cnt4);
    end
    clear_model();
    m_cnt = 0;
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic test_loads();
    logic [31:0] exp_v [4];
    logic [5:0]  ops   [4];
    logic [31:0] offs  [4];
    exp_v = '{32'hFFFF_FF81, 32'h0000_00F2, 32'h0000_7F04, 32'h0000_81F2};
    ops   = '{c_LB, c_LBU, c_LH, c_LHU};
    offs  = '{32'h100, 32'h101, 32'h102, 32'h100};
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 1, 5'd5, offs[i], 32'h81F2_7F04, 32'h0, ops[i], 32'h8C00_0000 + 32'(i));
      tick();
      n_tests++;
      if (wd !== exp_v[i] || dwb !== 1'b1 || wr !== 5'd5 || mis !== 1'b0) begin
        n_fail++;
        $display("FAIL load_%0d: got wd=%h dwb=%b wr=%0d mis=%b, expected wd=%h dwb=1 wr=5 mis=0",
                 i, wd, dwb, wr, mis, exp_v[i]);
      end
    end
  endtask

  task automatic test_lwl_lwr();
    logic [31:0] exp_v [3];
    logic [5:0]  ops   [3];
    logic [31:0] offs  [3];
    exp_v = '{32'h2233_44DD, 32'hAA11_2233, 32'h1122_3344};
    ops   = '{c_LWL, c_LWR, c_LWL};
    offs  = '{32'h201, 32'h202, 32'h200};
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 1, 5'd6, offs[i], 32'h1122_3344, 32'hAABB_CCDD, ops[i], 32'h8800_0000 + 32'(i));
      tick();
      n_tests++;
      if (wd !== exp_v[i]) begin
        n_fail++;
        $display("FAIL merge_%0d: got wd=%h, expected %h", i, wd, exp_v[i]);
      end
    end
  endtask

  task automatic test_misalign_zero();
    int unsigned c0;
    drive(1, 1, 1, 5'd9, 32'h0000_0103, 32'h81F2_7F04, 32'h0, c_LH, 32'h8400_0003);
    tick();
    c0 = m_cnt;
    n_tests++;
    if (mis !== 1'b1 || dwb !== 1'b0 || wd !== 32'd0) begin
      n_fail++;
      $display("FAIL misalign: got mis=%b dwb=%b wd=%h, expected mis=1 dwb=0 wd=0", mis, dwb, wd);
    end
    drive(1, 0, 1, 5'd0, 32'h0000_0077, 32'h0, 32'h0, 6'd0, 32'h2000_0077);
    tick();
    n_tests++;
    if (cnt32 !== c0 + 1) begin
      n_fail++;
      $display("FAIL misalign_count: got %0d, expected %0d", cnt32, c0 + 1);
    end
    n_tests++;
    if (dwb !== 1'b0 || dwb4 !== 1'b1 || wd !== 32'h77) begin
      n_fail++;
      $display("FAIL zero_guard: got dwb=%b dwb_noguard=%b wd=%h, expected dwb=0 dwb_noguard=1 wd=00000077",
               dwb, dwb4, wd);
    end
  endtask

  task automatic test_stall_flush();
    int unsigned c0;
    drive(1, 0, 1, 5'd7, 32'h1234_5678, 32'h0, 32'h0, 6'd0, 32'h2407_5678);
    tick();
    c0 = m_cnt;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 1, 5'd12, 32'hDEAD_BEE0, 32'h5555_AAAA, 32'h0, c_LB, 32'h8000_00EE);
      stall = 1'b1;
      tick();
      n_tests++;
      if (wd !== 32'h1234_5678 || wr !== 5'd7 || dwb !== 1'b1 || ins !== 32'h2407_5678 || cnt32 !== c0) begin
        n_fail++;
        $display("FAIL stall_%0d: got wd=%h wr=%0d dwb=%b ins=%h cnt=%0d, expected 12345678/7/1/24075678/%0d",
                 i, wd, wr, dwb, ins, cnt32, c0);
      end
    end
    stall = 1'b1;
    flush = 1'b1;
    tick();
    n_tests++;
    if (dwb !== 1'b0 || wd !== 32'd0 || ins !== 32'd0 || cnt32 !== c0) begin
      n_fail++;
      $display("FAIL flush_stall: got dwb=%b wd=%h ins=%h cnt=%0d, expected 0/0/0/%0d", dwb, wd, ins, cnt32, c0);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    n_tests++;
    if (cnt32 !== c0) begin
      n_fail++;
      $display("FAIL bubble_count: got %0d, expected %0d", cnt32, c0);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int i = 0; i < 17; i++) begin
      drive(1, 0, 1, 5'd1, 32'(i), 0, 0, 6'd0, 32'(i));
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    n_tests++;
    if (cnt4 !== 4'd1 || cnt32 !== 32'd17) begin
      n_fail++;
      $display("FAIL wrap: got cnt4=%0d cnt32=%0d, expected cnt4=1 cnt32=17", cnt4, cnt32);
    end
  endtask

  task automatic test_random();
    logic [5:0] op;
    int errs;
    errs = 0;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 6))
        0: op = c_LB;  1: op = c_LBU; 2: op = c_LH;  3: op = c_LHU;
        4: op = c_LWL; 5: op = c_LWR; default: op = 6'($urandom);
      endcase
      drive(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
            $urandom, $urandom, $urandom, op, $urandom);
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 7) == 0);
      tick();
      n_tests++;
      if (wd !== exp_wd() || wr !== m.wreg || ins !== m.instr || mis !== exp_mis() ||
          dwb !== exp_dwb(1'b1) || dwb4 !== exp_dwb(1'b0) ||
          cnt32 !== m_cnt || cnt4 !== 4'(m_cnt)) begin
        n_fail++;
        if (errs < 10)
          $display("FAIL random_%0d: got wd=%h wr=%0d ins=%h mis=%b dwb=%b dwb4=%b cnt=%0d cnt4=%0d, expected wd=%h wr=%0d ins=%h mis=%b dwb=%b dwb4=%b cnt=%0d",
                   n, wd, wr, ins, mis, dwb, dwb4, cnt32, cnt4,
                   exp_wd(), m.wreg, m.instr, exp_mis(), exp_dwb(1'b1), exp_dwb(1'b0), m_cnt);
        errs++;
      end
    end
  endtask

  initial begin
    RESET = 1'b1;
    clear_model();
    m_cnt = 0;
    test_reset();
    test_loads();
    test_lwl_lwr();
    test_misalign_zero();
    test_stall_flush();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
